adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled analog mux channels, starts one ADC conversion per channel, and
// queues the tagged {channel, result} words in a first-word-fall-through FIFO.
module adc_scan_sequencer #(
  parameter int ADC_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int EOC_TIMEOUT = 4096
) (
  input  logic                        sys_clk,
  input  logic                        reset_,
  input  logic                        enable,
  input  logic                        scan_start,
  input  logic                        continuous,
  input  logic [7:0]                  chan_mask,
  input  logic [7:0]                  settle_cycles,
  input  logic                        err_clr,
  input  logic                        adc_eoc,
  input  logic [ADC_WIDTH-1:0]        adc_data,
  input  logic                        rd_en,
  output logic [2:0]                  mux_sel,
  output logic                        adc_start,
  output logic [ADC_WIDTH+2:0]        rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic                        busy,
  output logic                        scan_done,
  output logic                        overflow,
  output logic                        timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(EOC_TIMEOUT + 1);
  localparam int DW = ADC_WIDTH + 3;
  localparam logic [TW-1:0] T_MAX    = TW'(EOC_TIMEOUT);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT_EOC, NEXT} state_t;

  state_t          state, state_d;
  logic [7:0]      mask_q;
  logic [7:0]      settle_cnt;
  logic [TW-1:0]   tout_cnt;
  logic [3:0]      lowest, following;
  logic [2:0]      ch_d;
  logic            load_settle, latch_mask, push_req, timeout_set;

  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   hold_q;
  logic            pop, push_ok, overflow_set;

  // Returns {found, index} of the lowest set bit of m at or above position 'from'.
  function automatic logic [3:0] first_set(input logic [7:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign lowest    = first_set(chan_mask, 0);
  assign following = first_set(mask_q, int'(mux_sel) + 1);

  always_comb begin
    state_d     = state;
    ch_d        = mux_sel;
    load_settle = 1'b0;
    latch_mask  = 1'b0;
    push_req    = 1'b0;
    timeout_set = 1'b0;
    adc_start   = 1'b0;
    scan_done   = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start && chan_mask != 8'h00) begin
          state_d     = SETTLE;
          ch_d        = lowest[2:0];
          latch_mask  = 1'b1;
          load_settle = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt <= 8'd1) state_d = CONVERT;
      end
      CONVERT: begin
        adc_start = 1'b1;
        state_d   = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (adc_eoc) begin
          push_req = 1'b1;
          state_d  = NEXT;
        end else if (tout_cnt == T_MAX) begin
          timeout_set = 1'b1;
          state_d     = NEXT;
        end
      end
      NEXT: begin
        if (following[3]) begin
          ch_d        = following[2:0];
          load_settle = 1'b1;
          state_d     = SETTLE;
        end else begin
          scan_done = 1'b1;
          if (continuous && chan_mask != 8'h00) begin
            ch_d        = lowest[2:0];
            latch_mask  = 1'b1;
            load_settle = 1'b1;
            state_d     = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable aborts everything except the FIFO contents and the sticky flags.
    if (!enable) begin
      state_d     = IDLE;
      ch_d        = mux_sel;
      load_settle = 1'b0;
      latch_mask  = 1'b0;
      push_req    = 1'b0;
      timeout_set = 1'b0;
      adc_start   = 1'b0;
      scan_done   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      mux_sel    <= 3'd0;
      mask_q     <= 8'h00;
      settle_cnt <= 8'd0;
      tout_cnt   <= '0;
    end else begin
      state   <= state_d;
      mux_sel <= ch_d;
      if (latch_mask) mask_q <= chan_mask;
      if (load_settle) settle_cnt <= (settle_cycles == 8'd0) ? 8'd1 : settle_cycles;
      else if (state == SETTLE && settle_cnt > 8'd1) settle_cnt <= settle_cnt - 8'd1;
      // Counts cycles elapsed since adc_start, so EOC_TIMEOUT itself is still in time.
      if (state == CONVERT) tout_cnt <= TW'(1);
      else if (state == WAIT_EOC && tout_cnt != T_MAX) tout_cnt <= tout_cnt + 1'b1;
    end
  end

  assign busy         = (state != IDLE);
  assign fifo_empty   = (fifo_level == '0);
  assign fifo_full    = (fifo_level == LVL_FULL);
  assign pop          = rd_en && !fifo_empty;
  assign push_ok      = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;
  // Once drained, the last popped word stays visible instead of stale memory.
  assign rd_data      = fifo_empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      hold_q      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {mux_sel, adc_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (overflow_set) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (timeout_set) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: a small ADC responder answers adc_start
// after a programmable delay, and each scenario task checks its own results inline.
module tb_adc_scan_sequencer;

  localparam int TO = 64;

  logic        sys_clk, reset_, enable, scan_start, continuous, err_clr, adc_eoc, rd_en;
  logic [7:0]  chan_mask, settle_cycles;
  logic [11:0] adc_data;
  logic [2:0]  mux_sel;
  logic        adc_start, fifo_empty, fifo_full, busy, scan_done, overflow, timeout_err;
  logic [14:0] rd_data;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int eoc_delay = 0;
  int start_cyc [64];
  int start_ch [64];
  int eoc_wait = 0;
  logic       eoc_pending = 1'b0;
  logic [7:0] eoc_seq = 8'h00;
  logic [2:0] eoc_ch = 3'd0;

  adc_scan_sequencer #(.ADC_WIDTH(12), .FIFO_DEPTH(8), .EOC_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset_(reset_), .enable(enable), .scan_start(scan_start),
    .continuous(continuous), .chan_mask(chan_mask), .settle_cycles(settle_cycles),
    .err_clr(err_clr), .adc_eoc(adc_eoc), .adc_data(adc_data), .rd_en(rd_en),
    .mux_sel(mux_sel), .adc_start(adc_start), .rd_data(rd_data), .fifo_level(fifo_level),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy), .scan_done(scan_done),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ADC model: answers adc_start after eoc_delay cycles (never if 0); data = {seq+0x51, 0, ch}.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    #1;
    adc_eoc = 1'b0;
    if (!reset_) begin
      eoc_pending = 1'b0;
      eoc_seq     = 8'h00;
    end else begin
      if (eoc_pending) begin
        eoc_wait = eoc_wait - 1;
        if (eoc_wait == 0) begin
          adc_eoc     = 1'b1;
          adc_data    = {eoc_seq + 8'h51, 1'b0, eoc_ch};
          eoc_seq     = eoc_seq + 8'h01;
          eoc_pending = 1'b0;
        end
      end
      if (adc_start) begin
        start_cyc[start_cnt % 64] = cyc;
        start_ch[start_cnt % 64]  = int'(mux_sel);
        start_cnt = start_cnt + 1;
        if (eoc_delay != 0) begin
          eoc_pending = 1'b1;
          eoc_wait    = eoc_delay;
          eoc_ch      = mux_sel;
        end
      end
      if (scan_done) done_cnt = done_cnt + 1;
    end
  end

  task automatic do_reset;
    @(negedge sys_clk);
    reset_ = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset_ = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++; if (mux_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_mux_sel got %0d exp 0", mux_sel); end
    checks++; if (adc_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_adc_start got %0b exp 0", adc_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_scan_done got %0b exp 0", scan_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got %0b exp 0", timeout_err); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b exp 0", fifo_full); end
    checks++; if (rd_data !== 15'h0) begin errors++; $display("[TB] FAIL reset_rd_data got %0h exp 0", rd_data); end
    reset_ = 1'b1;
  endtask

  task automatic test_basic_scan;
    int t, bs, bd;
    do_reset();
    @(negedge sys_clk);
    bs = start_cnt; bd = done_cnt; t = cyc;
    chan_mask = 8'h05; settle_cycles = 8'd3; eoc_delay = 10; continuous = 1'b0; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    chan_mask  = 8'hFF;
    for (int i = 0; i < 200 && done_cnt == bd; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    checks++; if (start_cnt - bs != 2) begin errors++; $display("[TB] FAIL basic_starts got %0d exp 2", start_cnt - bs); end
    checks++; if (start_cyc[bs % 64] != t + 4) begin errors++; $display("[TB] FAIL basic_latency got %0d exp %0d", start_cyc[bs % 64], t + 4); end
    checks++; if (start_ch[bs % 64] != 0) begin errors++; $display("[TB] FAIL basic_ch_first got %0d exp 0", start_ch[bs % 64]); end
    checks++; if (start_ch[(bs + 1) % 64] != 2) begin errors++; $display("[TB] FAIL basic_ch_second got %0d exp 2", start_ch[(bs + 1) % 64]); end
    checks++; if (done_cnt - bd != 1) begin errors++; $display("[TB] FAIL basic_scan_done got %0d exp 1", done_cnt - bd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got %0b exp 0", busy); end
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("[TB] FAIL basic_level got %0d exp 2", fifo_level); end
    checks++; if (rd_data !== 15'h0510) begin errors++; $display("[TB] FAIL basic_head0 got %0h exp 0510", rd_data); end
    rd_en = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0;
    checks++; if (rd_data !== 15'h2522) begin errors++; $display("[TB] FAIL basic_head1 got %0h exp 2522", rd_data); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("[TB] FAIL basic_level1 got %0d exp 1", fifo_level); end
    rd_en = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_drained got %0b exp 1", fifo_empty); end
    checks++; if (rd_data !== 15'h2522) begin errors++; $display("[TB] FAIL basic_hold got %0h exp 2522", rd_data); end
    rd_en = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0;
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL empty_pop_level got %0d exp 0", fifo_level); end
    checks++; if (rd_data !== 15'h2522) begin errors++; $display("[TB] FAIL empty_pop_hold got %0h exp 2522", rd_data); end
  endtask

  task automatic test_overflow;
    do_reset();
    @(negedge sys_clk);
    continuous = 1'b1; chan_mask = 8'h80; settle_cycles = 8'd1; eoc_delay = 2; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    for (int i = 0; i < 500 && fifo_full !== 1'b1; i++) @(negedge sys_clk);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL ovf_level8 got %0d exp 8", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %0b exp 0", overflow); end
    checks++; if (rd_data !== 15'h7517) begin errors++; $display("[TB] FAIL ovf_head got %0h exp 7517", rd_data); end
    for (int i = 0; i < 100 && overflow !== 1'b1; i++) @(negedge sys_clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %0b exp 1", overflow); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL ovf_level_hold got %0d exp 8", fifo_level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovf_continues got %0b exp 1", busy); end
    // err_clr together with a dropped push: the set must win.
    @(negedge sys_clk);
    for (int i = 0; i < 50 && adc_eoc !== 1'b1; i++) @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL set_wins got %0b exp 1", overflow); end
    // Pop in the same cycle as a push into a full FIFO.
    for (int i = 0; i < 50 && adc_eoc !== 1'b1; i++) @(negedge sys_clk);
    rd_en = 1'b1; err_clr = 1'b1;
    @(negedge sys_clk);
    rd_en = 1'b0; err_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_ovf got %0b exp 0", overflow); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL pushpop_level got %0d exp 8", fifo_level); end
    checks++; if (rd_data !== 15'h7527) begin errors++; $display("[TB] FAIL pushpop_head got %0h exp 7527", rd_data); end
    enable = 1'b0;
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_stop got %0b exp 0", busy); end
    enable = 1'b1; continuous = 1'b0;
  endtask

  task automatic test_timeout;
    int c, bs, bd;
    do_reset();
    @(negedge sys_clk);
    bs = start_cnt; bd = done_cnt;
    chan_mask = 8'h01; settle_cycles = 8'd2; eoc_delay = 0; continuous = 1'b0; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    for (int i = 0; i < 20 && start_cnt == bs; i++) @(negedge sys_clk);
    checks++; if (start_cnt - bs != 1) begin errors++; $display("[TB] FAIL to_start got %0d exp 1", start_cnt - bs); end
    c = start_cyc[bs % 64];
    for (int i = 0; i < 200 && cyc < c + TO - 1; i++) @(negedge sys_clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %0b exp 0", timeout_err); end
    for (int i = 0; i < 10 && cyc < c + TO + 1; i++) @(negedge sys_clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_set got %0b exp 1", timeout_err); end
    @(negedge sys_clk);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL to_no_push got %0b exp 1", fifo_empty); end
    checks++; if (done_cnt - bd != 1) begin errors++; $display("[TB] FAIL to_scan_done got %0d exp 1", done_cnt - bd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle got %0b exp 0", busy); end
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_clear got %0b exp 0", timeout_err); end
  endtask

  task automatic test_settle_zero;
    int t, bs, bd;
    do_reset();
    @(negedge sys_clk);
    chan_mask = 8'h00; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL empty_mask_ignored got %0b exp 0", busy); end
    bs = start_cnt; bd = done_cnt; t = cyc;
    chan_mask = 8'h10; settle_cycles = 8'd0; eoc_delay = 1; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    for (int i = 0; i < 50 && done_cnt == bd; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    checks++; if (start_cyc[bs % 64] != t + 2) begin errors++; $display("[TB] FAIL settle0_latency got %0d exp %0d", start_cyc[bs % 64], t + 2); end
    checks++; if (start_ch[bs % 64] != 4) begin errors++; $display("[TB] FAIL settle0_ch got %0d exp 4", start_ch[bs % 64]); end
    checks++; if (rd_data !== 15'h4514) begin errors++; $display("[TB] FAIL settle0_data got %0h exp 4514", rd_data); end
  endtask

  task automatic test_enable_abort;
    int bs, bd;
    do_reset();
    @(negedge sys_clk);
    bs = start_cnt; bd = done_cnt;
    chan_mask = 8'h0F; settle_cycles = 8'd5; eoc_delay = 3; continuous = 1'b0; scan_start = 1'b1;
    @(negedge sys_clk);
    scan_start = 1'b0;
    for (int i = 0; i < 300 && !(mux_sel == 3'd3 && busy === 1'b1); i++) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle got %0b exp 0", busy); end
    repeat (20) @(negedge sys_clk);
    checks++; if (start_cnt - bs != 3) begin errors++; $display("[TB] FAIL abort_starts got %0d exp 3", start_cnt - bs); end
    checks++; if (done_cnt - bd != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d exp 0", done_cnt - bd); end
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("[TB] FAIL abort_level got %0d exp 3", fifo_level); end
    checks++; if (rd_data !== 15'h0510) begin errors++; $display("[TB] FAIL abort_head got %0h exp 0510", rd_data); end
    enable = 1'b1;
  endtask

  initial begin
    reset_ = 1'b0; enable = 1'b1; scan_start = 1'b0; continuous = 1'b0; err_clr = 1'b0;
    rd_en = 1'b0; chan_mask = 8'h00; settle_cycles = 8'd0; adc_eoc = 1'b0; adc_data = 12'h000;
    test_reset();
    test_basic_scan();
    test_overflow();
    test_timeout();
    test_settle_zero();
    test_enable_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
